wb_master_ctrl: RTL and testbench

Single-outstanding Wishbone classic-cycle master. It turns a simple valid/ready command interface (one read or write per command) into a Wishbone bus cycle. It completes against slaves that hold ack until stb drops and then release it a cycle later. It sits between fabric control logic (sequencers, register loaders) and the Wishbone bus of the team's BRAM/register slaves, and it bounds every cycle with a timeout so that a dead slave cannot hang the fabric.

---
 rtl/wb_master_ctrl.sv | 173 +++++++++++++++++
 tb/tb_wb_master_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_ctrl.sv
// Single-outstanding Wishbone classic-cycle master: one valid/ready command in,
// one bus cycle out, one response back, with a bounded wait for ack and for ack release.
module wb_master_ctrl #(
   parameter int BUS_DATA_WIDTH = 32,
   parameter int BUS_ADDR_WIDTH = 8,
   parameter int BUS_BE_WIDTH   = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                      wbm_clk_i,
   input  logic                      wbm_rst_i,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_we,
   input  logic [BUS_ADDR_WIDTH-1:0] cmd_adr,
   input  logic [BUS_DATA_WIDTH-1:0] cmd_dat,
   input  logic [BUS_BE_WIDTH-1:0]   cmd_sel,
   output logic                      rsp_valid,
   output logic [BUS_DATA_WIDTH-1:0] rsp_dat,
   output logic                      rsp_err,
   output logic                      busy,
   output logic                      wbm_cyc_o,
   output logic                      wbm_stb_o,
   output logic                      wbm_we_o,
   output logic [BUS_BE_WIDTH-1:0]   wbm_sel_o,
   output logic [BUS_ADDR_WIDTH-1:0] wbm_adr_o,
   output logic [BUS_DATA_WIDTH-1:0] wbm_dat_o,
   input  logic [BUS_DATA_WIDTH-1:0] wbm_dat_i,
   input  logic                      wbm_ack_i
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   localparam logic        TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [15:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? 16'd0 : 16'(TIMEOUT_CYCLES - 1);

   state_t                    state_q, state_d;
   logic [15:0]               timer_q, timer_d, timer_inc;
   logic                      req_q, req_d;
   logic                      we_q, we_d;
   logic [BUS_ADDR_WIDTH-1:0] adr_q, adr_d;
   logic [BUS_DATA_WIDTH-1:0] dat_q, dat_d;
   logic [BUS_BE_WIDTH-1:0]   sel_q, sel_d;
   logic                      rsp_valid_q, rsp_valid_d;
   logic                      rsp_err_q, rsp_err_d;
   logic [BUS_DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
   logic                      accept;

   // A lingering ack must never be taken as the answer to a new request, so it gates acceptance.
   assign cmd_ready = (state_q == ST_IDLE) & ~wbm_ack_i;
   assign accept    = cmd_valid & cmd_ready;
   assign timer_inc = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;

   assign busy      = (state_q != ST_IDLE);
   assign wbm_cyc_o = req_q;
   assign wbm_stb_o = req_q;
   assign wbm_we_o  = we_q;
   assign wbm_adr_o = adr_q;
   assign wbm_dat_o = dat_q;
   assign wbm_sel_o = sel_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_dat   = rsp_dat_q;

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      req_d       = req_q;
      we_d        = we_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      sel_d       = sel_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = rsp_err_q;
      rsp_dat_d   = rsp_dat_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               req_d   = 1'b1;
               we_d    = cmd_we;
               adr_d   = cmd_adr;
               dat_d   = cmd_dat;
               sel_d   = cmd_sel;
               timer_d = 16'd0;
               state_d = ST_REQ;
            end else begin
               timer_d = 16'd0;
            end
         end
         ST_REQ: begin
            timer_d = timer_inc;
            if (wbm_ack_i) begin
               req_d       = 1'b0;
               we_d        = 1'b0;
               adr_d       = '0;
               dat_d       = '0;
               sel_d       = '0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_dat_d   = we_q ? '0 : wbm_dat_i;
               timer_d     = 16'd0;
               state_d     = ST_RELEASE;
            end else if (TO_EN && (timer_q == TO_LAST)) begin
               req_d       = 1'b0;
               we_d        = 1'b0;
               adr_d       = '0;
               dat_d       = '0;
               sel_d       = '0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_dat_d   = '0;
               timer_d     = 16'd0;
               state_d     = ST_RELEASE;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_RELEASE: begin
            // A slave with ack stuck high is abandoned after the timeout; cmd_ready still waits for it.
            timer_d = timer_inc;
            if (!wbm_ack_i) begin
               timer_d = 16'd0;
               state_d = ST_IDLE;
            end else if (TO_EN && (timer_q == TO_LAST)) begin
               timer_d = 16'd0;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RELEASE;
            end
         end
         default: begin
            req_d   = 1'b0;
            we_d    = 1'b0;
            adr_d   = '0;
            dat_d   = '0;
            sel_d   = '0;
            timer_d = 16'd0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge wbm_clk_i) begin
      if (wbm_rst_i) begin
         state_q     <= ST_IDLE;
         timer_q     <= 16'd0;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         adr_q       <= '0;
         dat_q       <= '0;
         sel_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_dat_q   <= '0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         req_q       <= req_d;
         we_q        <= we_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         sel_q       <= sel_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_dat_q   <= rsp_dat_d;
      end
   end

endmodule

// File: tb/tb_wb_master_ctrl.sv
// Scoreboard bench for wb_master_ctrl: a behavioural slave, an accept monitor that
// queues expected bus cycles and responses, and monitors that pop and compare them.
module tb_wb_master_ctrl;
   localparam int DW = 32;
   localparam int AW = 8;
   localparam int BW = 4;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready, cmd_we;
   logic [AW-1:0] cmd_adr;
   logic [DW-1:0] cmd_dat;
   logic [BW-1:0] cmd_sel;
   logic          rsp_valid, rsp_err, busy;
   logic [DW-1:0] rsp_dat;
   logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [BW-1:0] wbm_sel_o;
   logic [AW-1:0] wbm_adr_o;
   logic [DW-1:0] wbm_dat_o;
   logic [DW-1:0] wbm_dat_i = 32'hA5A5_5A5A;
   logic          wbm_ack_i = 1'b0;

   always #5 clk = ~clk;

   wb_master_ctrl #(.BUS_DATA_WIDTH(DW), .BUS_ADDR_WIDTH(AW), .BUS_BE_WIDTH(BW),
                    .TIMEOUT_CYCLES(TO)) dut (
      .wbm_clk_i(clk), .wbm_rst_i(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
      .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .rsp_err(rsp_err), .busy(busy),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
      .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
      .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
   );

   typedef struct packed {logic err; logic [DW-1:0] dat;} rsp_t;
   typedef struct packed {logic we; logic [AW-1:0] adr; logic [DW-1:0] dat; logic [BW-1:0] sel;} bus_t;

   rsp_t exp_rsp_q[$];
   bus_t exp_bus_q[$];
   bus_t cur_bus;
   int   n_checks = 0;
   int   n_errors = 0;
   int   rsp_count = 0;
   int   stb_len = 0;
   int   last_stb_len = 0;
   logic prev_stb = 1'b0;

   // slave knobs
   int            slv_delay = 1;
   bit            slv_never = 1'b0;
   bit            slv_stuck = 1'b0;
   bit            slv_force = 1'b0;
   logic [DW-1:0] slv_rdata = 32'h0;
   int            slv_cnt = 0;
   bit            slv_held = 1'b0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Slave: acks slv_delay cycles into stb, holds ack one cycle past stb falling.
   always @(posedge clk) begin
      #1;
      if (rst) begin
         wbm_ack_i = 1'b0; slv_cnt = 0; slv_held = 1'b0;
      end else if (slv_force) begin
         wbm_ack_i = 1'b1; wbm_dat_i = 32'hA5A5_5A5A;
      end else if (wbm_stb_o) begin
         slv_cnt++;
         if (!slv_never && slv_cnt >= slv_delay) begin
            wbm_ack_i = 1'b1; wbm_dat_i = slv_rdata;
         end
      end else begin
         slv_cnt = 0;
         wbm_dat_i = 32'hA5A5_5A5A;
         if (slv_stuck) begin
            slv_held = 1'b0;
         end else if (wbm_ack_i && !slv_held) begin
            slv_held = 1'b1;
         end else begin
            wbm_ack_i = 1'b0; slv_held = 1'b0;
         end
      end
   end

   // Monitors: accept -> push expectations; bus and response -> pop and compare.
   always @(negedge clk) begin
      if (!rst) begin
         if (cmd_valid && cmd_ready) begin
            exp_bus_q.push_back('{we: cmd_we, adr: cmd_adr, dat: cmd_dat, sel: cmd_sel});
            exp_rsp_q.push_back('{err: slv_never,
                                  dat: (cmd_we || slv_never) ? 32'h0 : slv_rdata});
         end
         if (rsp_valid) begin
            rsp_count++;
            if (exp_rsp_q.size() == 0) begin
               check_eq("rsp_unexpected", 64'd1, 64'd0);
            end else begin
               rsp_t e;
               e = exp_rsp_q.pop_front();
               check_eq("rsp_dat", 64'(rsp_dat), 64'(e.dat));
               check_eq("rsp_err", 64'(rsp_err), 64'(e.err));
            end
         end
         if (wbm_stb_o && !prev_stb) begin
            if (exp_bus_q.size() == 0) check_eq("bus_unexpected", 64'd1, 64'd0);
            else cur_bus = exp_bus_q.pop_front();
            stb_len = 0;
         end
         if (wbm_stb_o) begin
            stb_len++;
            check_eq("bus_hold", 64'({wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o}), 64'(cur_bus));
            check_eq("cyc_with_stb", 64'(wbm_cyc_o), 64'd1);
         end else if (prev_stb) begin
            last_stb_len = stb_len;
            check_eq("bus_cleared", 64'({wbm_cyc_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o}), 64'd0);
         end
         if (wbm_ack_i) check_eq("ready_while_ack", 64'(cmd_ready), 64'd0);
      end
      prev_stb = wbm_stb_o;
   end

   // Called at posedge+1; returns at posedge+1 of the accepting edge with cmd_valid still high.
   task automatic send(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                       input logic [BW-1:0] sel);
      bit done = 1'b0;
      cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         done = cmd_ready;
         @(posedge clk); #1;
      end
      if (!done) check_eq("accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_done(input int target);
      bit done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(posedge clk); #1;
         done = (rsp_count >= target) && !busy;
      end
      if (!done) check_eq("done_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int n;
      rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("reset_bus", 64'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o}), 64'd0);
      check_eq("reset_rsp", 64'({rsp_valid, rsp_err, busy, rsp_dat}), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("ready_after_reset", 64'(cmd_ready), 64'd1);
      @(posedge clk); #1;

      // 1: write, ack after 5 stb cycles
      slv_delay = 5; base = rsp_count;
      send(1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF);
      cmd_valid = 1'b0;
      wait_done(base + 1);
      check_eq("wr_stb_len", 64'(last_stb_len), 64'd5);
      check_eq("wr_rsp_count", 64'(rsp_count - base), 64'd1);

      // 2: read, same-cycle ack
      slv_delay = 1; slv_rdata = 32'h1234_5678; base = rsp_count;
      send(1'b0, 8'h20, 32'h0, 4'hF);
      cmd_valid = 1'b0;
      wait_done(base + 1);
      check_eq("rd_stb_len", 64'(last_stb_len), 64'd1);

      // 3: timeout, then a normal read
      slv_never = 1'b1; base = rsp_count;
      send(1'b1, 8'h30, 32'h0BAD_CAFE, 4'h3);
      cmd_valid = 1'b0;
      wait_done(base + 1);
      check_eq("to_stb_len", 64'(last_stb_len), 64'd16);
      slv_never = 1'b0; slv_delay = 2; slv_rdata = 32'hCAFE_F00D;
      send(1'b0, 8'h31, 32'h0, 4'hC);
      cmd_valid = 1'b0;
      wait_done(base + 2);

      // 4: back-to-back writes with cmd_valid held
      base = rsp_count;
      send(1'b1, 8'h01, 32'h1111_1111, 4'h1);
      send(1'b1, 8'h02, 32'h2222_2222, 4'h2);
      send(1'b1, 8'h03, 32'h3333_3333, 4'h4);
      cmd_valid = 1'b0;
      wait_done(base + 3);
      check_eq("b2b_rsp_count", 64'(rsp_count - base), 64'd3);
      check_eq("b2b_bus_left", 64'(exp_bus_q.size()), 64'd0);

      // 5: reset two cycles into a read
      slv_never = 1'b1; base = rsp_count;
      send(1'b0, 8'h40, 32'h0, 4'hF);
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      exp_rsp_q.delete(); exp_bus_q.delete();
      @(posedge clk);
      @(negedge clk);
      check_eq("rst_mid_bus", 64'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o, wbm_dat_o}), 64'd0);
      check_eq("rst_mid_rsp", 64'({rsp_valid, rsp_err, busy, rsp_dat}), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0; slv_never = 1'b0; slv_delay = 3; slv_rdata = 32'h0BAD_F00D;
      check_eq("rst_mid_no_rsp", 64'(rsp_count - base), 64'd0);
      send(1'b0, 8'h41, 32'h0, 4'hF);
      cmd_valid = 1'b0;
      wait_done(base + 1);
      check_eq("post_rst_stb_len", 64'(last_stb_len), 64'd3);

      // 6a: spurious ack in IDLE blocks acceptance
      slv_delay = 1; base = rsp_count;
      slv_force = 1'b1;
      @(posedge clk); #1;
      fork
         send(1'b1, 8'h50, 32'h5050_5050, 4'hF);
         begin
            repeat (4) @(posedge clk);
            #1 slv_force = 1'b0;
         end
      join
      cmd_valid = 1'b0;
      check_eq("spurious_no_rsp", 64'(rsp_count - base), 64'd0);
      wait_done(base + 1);

      // 6b: ack stuck high after a transaction
      slv_stuck = 1'b1; base = rsp_count;
      send(1'b1, 8'h60, 32'h6060_6060, 4'hA);
      cmd_valid = 1'b0;
      n = 0;
      while (busy && n < 200) begin
         n++;
         @(posedge clk); #1;
      end
      check_eq("stuck_busy_cycles", 64'(n), 64'd17);
      check_eq("stuck_ack_high", 64'(wbm_ack_i), 64'd1);
      check_eq("stuck_not_ready", 64'(cmd_ready), 64'd0);
      fork
         send(1'b1, 8'h61, 32'h6161_6161, 4'h5);
         begin
            repeat (5) @(posedge clk);
            #1 slv_stuck = 1'b0;
         end
      join
      cmd_valid = 1'b0;
      check_eq("stuck_single_rsp", 64'(rsp_count - base), 64'd1);
      wait_done(base + 2);

      check_eq("rsp_queue_empty", 64'(exp_rsp_q.size()), 64'd0);
      check_eq("bus_queue_empty", 64'(exp_bus_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
